// File: rtl/tdm_mux8_serializer.sv
// tdm_mux8_serializer: captures an 8-bit word and shifts it out one bit per clock.
// Each bit is sent together with its slot select {x2,x1,x0}, so a downstream 1-to-8
// demux can route it back to the matching output line.
// Optional feature macro: TDM_MUX8_PARITY_EN adds a trailing even-parity slot and
// the par_slot output.
module tdm_mux8_serializer #(
  parameter bit MSB_FIRST = 1'b0,
  parameter bit IDLE_VAL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       ready,
  output logic       busy,
  output logic       out,
  output logic       valid,
  output logic       x0,
  output logic       x1,
  output logic       x2,
  output logic       done
`ifdef TDM_MUX8_PARITY_EN
  ,
  output logic       par_slot
`endif
);

  localparam logic [2:0] CntFirst = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] CntLast  = MSB_FIRST ? 3'd0 : 3'd7;

  typedef enum logic [1:0] {StIdle, StSend, StParity} state_e;

  state_e     state_q, state_d;
  logic [7:0] shadow_q, shadow_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       terminal;
  logic [2:0] sel;

  // Cycle in which a new load may be accepted while a word is still in flight.
`ifdef TDM_MUX8_PARITY_EN
  assign terminal = (state_q == StParity);
`else
  assign terminal = (state_q == StSend) && (cnt_q == CntLast);
`endif

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      shadow_q <= 8'd0;
      cnt_q    <= 3'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // Next-state: capture on load when idle or terminal, step the slot counter otherwise.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (load) begin
          state_d  = StSend;
          shadow_d = data_in;
          cnt_d    = CntFirst;
        end
      end
      StSend: begin
        if (cnt_q == CntLast) begin
`ifdef TDM_MUX8_PARITY_EN
          state_d = StParity;
          cnt_d   = 3'd0;
`else
          done_d = 1'b1;
          if (load) begin
            shadow_d = data_in;
            cnt_d    = CntFirst;
          end else begin
            state_d = StIdle;
            cnt_d   = 3'd0;
          end
`endif
        end else begin
          cnt_d = MSB_FIRST ? (cnt_q - 3'd1) : (cnt_q + 3'd1);
        end
      end
`ifdef TDM_MUX8_PARITY_EN
      StParity: begin
        done_d = 1'b1;
        if (load) begin
          state_d  = StSend;
          shadow_d = data_in;
          cnt_d    = CntFirst;
        end else begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Outputs decoded from registers only; no path from data_in/load to the link.
  always_comb begin
    out   = IDLE_VAL;
    valid = 1'b0;
    busy  = 1'b0;
    sel   = 3'd0;
    case (state_q)
      StSend: begin
        out   = shadow_q[cnt_q];
        valid = 1'b1;
        busy  = 1'b1;
        sel   = cnt_q;
      end
      StParity: begin
        out   = ^shadow_q;
        valid = 1'b1;
        busy  = 1'b1;
      end
      default: ;
    endcase
    ready = (state_q == StIdle) || terminal;
    done  = done_q;
    x0    = sel[0];
    x1    = sel[1];
    x2    = sel[2];
`ifdef TDM_MUX8_PARITY_EN
    par_slot = (state_q == StParity);
`endif
  end

endmodule

// File: tb/tb_tdm_mux8_serializer.sv
// Self-checking bench for tdm_mux8_serializer against a word/position reference model.
module tb_tdm_mux8_serializer;

  localparam bit MSB_FIRST = 1'b0;
  localparam bit IDLE_VAL  = 1'b0;
`ifdef TDM_MUX8_PARITY_EN
  localparam int WordLen = 9;
`else
  localparam int WordLen = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic       load = 1'b0;
  logic       ready, busy, out, valid, x0, x1, x2, done;
  logic       par_w;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: is a word in flight, which position of it is on the wire.
  logic       m_busy = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_word = 8'd0;
  logic       m_done = 1'b0;

  always #5 clk = ~clk;

  tdm_mux8_serializer #(
    .MSB_FIRST(MSB_FIRST),
    .IDLE_VAL (IDLE_VAL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .load    (load),
    .ready   (ready),
    .busy    (busy),
    .out     (out),
    .valid   (valid),
    .x0      (x0),
    .x1      (x1),
    .x2      (x2),
    .done    (done)
`ifdef TDM_MUX8_PARITY_EN
    ,
    .par_slot(par_w)
`endif
  );

`ifndef TDM_MUX8_PARITY_EN
  assign par_w = 1'b0;
`endif

  wire [8:0] obs = {ready, busy, valid, out, x2, x1, x0, done, par_w};

  // Expected {ready,busy,valid,out,sel[2:0],done,par} for the current cycle.
  function automatic logic [8:0] model_vec();
    int   idx;
    logic b;
    logic [2:0] s;
    logic p;
    if (!m_busy) return {1'b1, 1'b0, 1'b0, IDLE_VAL, 3'b000, m_done, 1'b0};
    if (m_pos < 8) begin
      idx = MSB_FIRST ? 7 - m_pos : m_pos;
      b   = m_word[idx];
      s   = idx[2:0];
      p   = 1'b0;
    end else begin
      b = ^m_word;
      s = 3'd0;
      p = 1'b1;
    end
    return {(m_pos == WordLen - 1), 1'b1, 1'b1, b, s, m_done, p};
  endfunction

  // Apply inputs for one clock edge, advance the model, settle past the edge.
  task automatic tick(input logic r, input logic ld, input logic [7:0] d);
    rst = r;
    load = ld;
    data_in = d;
    @(posedge clk);
    if (r) begin
      m_busy = 1'b0;
      m_pos  = 0;
      m_done = 1'b0;
    end else begin
      m_done = m_busy && (m_pos == WordLen - 1);
      if (m_busy && (m_pos != WordLen - 1)) begin
        m_pos++;
      end else if (ld) begin
        m_busy = 1'b1;
        m_pos  = 0;
        m_word = d;
      end else begin
        m_busy = 1'b0;
        m_pos  = 0;
      end
    end
    cyc++;
    #1;
    rst = 1'b0;
    load = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 8'($urandom));
      n_cmp++;
      if (obs !== {1'b1, 1'b0, 1'b0, IDLE_VAL, 3'b000, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs,
                 {1'b1, 1'b0, 1'b0, IDLE_VAL, 3'b000, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_0101;  // A5 wire order for LSB first: 1,0,1,0,0,1,0,1
    tick(1'b0, 1'b1, 8'hA5);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (valid !== 1'b1 || out !== exp_bits[k] || {x2, x1, x0} !== 3'(k)) begin
        n_bad++;
        $display("FAIL basic_slot%0d got=v%b o%b s%0d exp=v1 o%b s%0d", k, valid, out,
                 {x2, x1, x0}, exp_bits[k], k);
      end
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++;
        $display("FAIL basic_model cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
      tick(1'b0, 1'b0, 8'h00);
    end
`ifndef TDM_MUX8_PARITY_EN
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done got=d%b v%b exp=d1 v0", done, valid);
    end
`endif
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 8'h00);
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++;
        $display("FAIL basic_tail cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
    end
  endtask

  task automatic test_ignored_load();
    int nvalid;
    nvalid = 0;
    tick(1'b0, 1'b1, 8'h3C);
    for (int k = 1; k <= 14; k++) begin
      if (valid === 1'b1) nvalid++;
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++;
        $display("FAIL ignored_load cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
      tick(1'b0, (k >= 2 && k <= 7), 8'hFF);
    end
    n_cmp++;
    if (nvalid !== WordLen) begin
      n_bad++;
      $display("FAIL ignored_count got=%0d exp=%0d", nvalid, WordLen);
    end
  endtask

  task automatic test_back_to_back();
    int nvalid, ndone, first_done, last_done;
    nvalid = 0;
    ndone = 0;
    first_done = -1;
    last_done = -1;
    tick(1'b0, 1'b1, 8'h81);
    for (int k = 1; k <= 2 * WordLen + 4; k++) begin
      if (valid === 1'b1) nvalid++;
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = k;
        last_done = k;
      end
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
      tick(1'b0, (k == WordLen), (k == WordLen) ? 8'h7E : 8'h00);
    end
    n_cmp++;
    if (nvalid !== 2 * WordLen || ndone !== 2 || last_done - first_done !== WordLen) begin
      n_bad++;
      $display("FAIL b2b_counts got=valid%0d done%0d gap%0d exp=valid%0d done2 gap%0d",
               nvalid, ndone, last_done - first_done, 2 * WordLen, WordLen);
    end
  endtask

  task automatic test_abort();
    tick(1'b0, 1'b1, 8'hF0);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if ({x2, x1, x0} !== 3'd3) begin
      n_bad++;
      $display("FAIL abort_slot got=%0d exp=3", {x2, x1, x0});
    end
    tick(1'b1, 1'b1, 8'hAA);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs !== {1'b1, 1'b0, 1'b0, IDLE_VAL, 3'b000, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL abort_idle cyc=%0d got=%b exp=%b", cyc, obs,
                 {1'b1, 1'b0, 1'b0, IDLE_VAL, 3'b000, 1'b0, 1'b0});
      end
      tick(1'b0, 1'b0, 8'h00);
    end
    tick(1'b0, 1'b1, 8'h0F);
    for (int k = 0; k < WordLen + 2; k++) begin
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++;
        $display("FAIL abort_reload cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
      tick(1'b0, 1'b0, 8'h00);
    end
  endtask

`ifdef TDM_MUX8_PARITY_EN
  task automatic test_parity();
    tick(1'b0, 1'b1, 8'h07);
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (par_w !== 1'b1 || out !== 1'b1 || valid !== 1'b1 || {x2, x1, x0} !== 3'd0) begin
      n_bad++;
      $display("FAIL parity_slot got=p%b o%b v%b s%0d exp=p1 o1 v1 s0", par_w, out, valid,
               {x2, x1, x0});
    end
    tick(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_done got=d%b v%b exp=d1 v0", done, valid);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 40), 8'($urandom));
      n_cmp++;
      if (obs !== model_vec()) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored_load();
    test_back_to_back();
    test_abort();
`ifdef TDM_MUX8_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_mux8_serializer.md
Name: tdm_mux8_serializer

Overview:
- Transmit-side counterpart of the 1-to-8 demultiplexer tree. Captures an 8-bit parallel word and sends it one bit per clock through an 8:1 selection.
- Drives a 3-bit select (x0 = LSB, x1, x2) alongside each bit, so a downstream 1-to-8 demux can route every bit back to its matching output line.
- Sits between a parallel source and a single-wire TDM link.

Parameters:
MSB_FIRST, 0, 0: bit order 0->7 (select counts up); 1: bit order 7->0 (select counts down).
IDLE_VAL, 0, constant driven on `out` whenever no bit is valid (0 rather than high-Z, for FPGA use).

Ports:
clk      input   1  rising-edge clock
rst      input   1  synchronous reset, active-high
data_in  input   8  parallel word; bit i is sent in slot i
load     input   1  request to capture data_in
ready    output  1  high when a load this cycle will be accepted
busy     output  1  high while a word is in flight
out      output  1  serial bit
valid    output  1  out carries a data (or parity) bit this cycle
x0       output  1  slot select bit 0
x1       output  1  slot select bit 1
x2       output  1  slot select bit 2
done     output  1  one-cycle pulse in the cycle after the last slot of a word

Behaviour:
- Reset:
  - Sampled only on a clk rising edge with rst=1. Forces state IDLE, shadow register = 0, counter = 0.
  - Outputs after reset: out=IDLE_VAL, valid=0, busy=0, ready=1, done=0, {x2,x1,x0}=0.
  - rst mid-word aborts the word immediately. No done pulse is issued for it. rst wins over a simultaneous load.
- Registers:
  - 8-bit shadow data register.
  - 3-bit slot counter cnt.
  - State register: IDLE, SEND (plus PARITY under the option).
  - done flop.
- Outputs are decoded from registers only. No combinational path from data_in/load to out, valid or the selects.
- IDLE:
  - valid=0, out=IDLE_VAL, selects=0, busy=0, ready=1.
  - load=1 at an edge: shadow <= data_in; cnt <= 0 (or 7 if MSB_FIRST); go to SEND.
- SEND:
  - valid=1, out=shadow[cnt], {x2,x1,x0}=cnt, busy=1.
  - Each edge steps cnt by +1 (or -1 if MSB_FIRST).
  - Latency: load sampled at edge N puts the first bit on out during cycle N+1. A word occupies exactly 8 consecutive valid cycles.
- Last slot (cnt=7, or cnt=0 if MSB_FIRST):
  - ready=1.
  - At the next edge: done <= 1.
  - If load=1 at that edge, capture data_in, reset cnt and stay in SEND. This is back-to-back operation with zero idle cycles.
  - Otherwise go to IDLE.
  - The counter never wraps silently; the wrap is always the terminal transition.
- ready=0 in all non-terminal SEND cycles. Any load there is ignored; no error flag, no change to shadow.
- data_in changes while busy do not affect the word in flight.
- done is high for exactly one cycle per completed word, including back-to-back words. It may be high together with valid=1 of the next word.

Optional Feature:
Macro: TDM_MUX8_PARITY_EN.
- Defined:
  - Adds state PARITY after the last data slot: valid=1, out = XOR of all 8 shadow bits (even parity), {x2,x1,x0}=0.
  - Adds output port par_slot (1 bit), high only in the PARITY cycle.
  - The terminal-slot rules (ready=1, back-to-back load, done at next edge) move from the last data slot to the PARITY cycle.
  - A word then takes 9 valid cycles.
- Not defined:
  - No PARITY state and no par_slot port.
  - Behaviour exactly as described above.

Test Plan:
1. Reset release, then idle 5 cycles -> valid=0, out=0, ready=1, busy=0, done=0 every cycle.
2. MSB_FIRST=0, load data_in=8'hA5 for 1 cycle -> next 8 cycles out=1,0,1,0,0,1,0,1; selects=0..7; then done=1 for one cycle; then IDLE.
3. Load 8'h3C, then assert load with 8'hFF in cycles 2-7 of the word -> those loads are ignored; 8'h3C is sent intact and no second word follows.
4. Load 8'h81, then load 8'h7E held in the last-slot cycle -> 16 consecutive valid cycles carrying 81 then 7E; done pulses twice, 8 cycles apart.
5. Load 8'hF0, assert rst during slot 3 -> the next cycle shows IDLE outputs, no done pulse, and a subsequent load 8'h0F serializes correctly.
6. With TDM_MUX8_PARITY_EN defined, load 8'h07 -> 8 data bits, then a 9th cycle with par_slot=1, out=1, selects=0; done follows after the 9th cycle.
